wb_rr_arbiter: RTL and testbench

Round-robin Wishbone arbiter that shares one slave port among `NM` bus masters: the LM32 instruction bus, the LM32 data bus, and a camera DMA master. It sits between the masters and `conbus`' master side, or in front of a single shared slave such as `wb_bram`. It holds a grant for the whole of a master's `cyc` cycle. A watchdog terminates transfers the slave never acknowledges.

---
 rtl/wb_arb_pkg.sv | 45 ++++
 rtl/wb_arb_watchdog.sv | 40 ++++
 rtl/wb_rr_arbiter.sv | 115 +++++++++++
 tb/tb_wb_rr_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and the rotating-priority helper for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    localparam int unsigned MAX_NM = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    // First requester after 'last' in rotating order (last+1 .. last), one-hot; zero if none.
    function automatic logic [MAX_NM-1:0] rr_next(
        input logic [MAX_NM-1:0] req,
        input logic [IDX_W-1:0]  last,
        input int unsigned       nm
    );
        logic [MAX_NM-1:0] win;
        logic              found;
        int unsigned       idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_NM; k++) begin
            idx = ({29'd0, last} + k) % nm;
            if (k <= nm && !found && req[idx[IDX_W-1:0]]) begin
                win[idx[IDX_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
        return win;
    endfunction

    // Index of the set bit of a one-hot vector.
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [MAX_NM-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_NM; i++) begin
            if (vec[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Watchdog for the arbiter: flags a strobe that has waited TIMEOUT cycles without ack.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    input  logic clear,
    output logic to_hit
);

    if (TIMEOUT > 0) begin : g_wd
        localparam int unsigned    CW    = $clog2(TIMEOUT + 1);
        localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT);

        logic [CW-1:0] cnt;

        // to_hit is independent of ack so the slave's ack path cannot loop back through stb.
        assign to_hit = active && (cnt == LIMIT);

        // Count stalled strobe cycles; clear on ack, on timeout, on ownership change or idle strobe.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
            end else if (clear || ack || to_hit || !active) begin
                cnt <= '0;
            end else if (cnt != LIMIT) begin
                cnt <= cnt + CW'(1);
            end
        end
    end else begin : g_no_wd
        logic unused_wd;
        assign unused_wd = ^{clk, rst, active, ack, clear};
        assign to_hit    = 1'b0;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave port, grant held for a whole cyc.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NM      = 3,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NM*AW-1:0] m_adr_i,
    input  logic [NM*DW-1:0] m_dat_i,
    input  logic [NM*4-1:0]  m_sel_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    output logic [DW-1:0]    m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [AW-1:0]    s_adr_o,
    output logic [DW-1:0]    s_dat_o,
    output logic [3:0]       s_sel_o,
    output logic             s_we_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [DW-1:0]    s_dat_i,
    input  logic             s_ack_i,
    output logic [NM-1:0]    grant_o,
    output logic             busy_o
);

    arb_state_t         state;
    logic [NM-1:0]      grant;
    logic [IDX_W-1:0]   last;

    logic [MAX_NM-1:0]  req_ext;
    logic [MAX_NM-1:0]  win_ext;
    logic [NM-1:0]      win;
    logic [IDX_W-1:0]   win_idx;
    logic               owner_cyc;
    logic               owner_stb;
    logic               arb_take;
    logic               own_change;
    logic               to_hit;

    // Owner-selected slave-side signals; the registered one-hot grant drives the mux.
    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (grant[i]) begin
                owner_cyc = m_cyc_i[i];
                owner_stb = m_stb_i[i];
                s_adr_o   = m_adr_i[i*AW +: AW];
                s_dat_o   = m_dat_i[i*DW +: DW];
                s_sel_o   = m_sel_i[i*4 +: 4];
                s_we_o    = m_we_i[i];
            end
        end
    end

    // Rotating-priority winner and whether this edge re-arbitrates.
    always_comb begin
        req_ext         = '0;
        req_ext[NM-1:0] = m_cyc_i;
        win_ext         = rr_next(req_ext, last, NM);
        win             = win_ext[NM-1:0];
        win_idx         = onehot_idx(win_ext);
        arb_take        = (state == ARB_IDLE) || !owner_cyc;
        own_change      = arb_take && (win != grant);
    end

    // Grant FSM: re-arbitrate when idle or when the owner has released cyc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
            grant <= '0;
            last  <= IDX_W'(NM - 1);
        end else if (arb_take) begin
            if (|win) begin
                state <= ARB_OWNED;
                grant <= win;
                last  <= win_idx;
            end else begin
                state <= ARB_IDLE;
                grant <= '0;
            end
        end
    end

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .active (owner_cyc && owner_stb),
        .ack    (s_ack_i),
        .clear  (own_change),
        .to_hit (to_hit)
    );

    assign grant_o = grant;
    assign busy_o  = |grant;
    assign s_cyc_o = owner_cyc & busy_o;
    assign s_stb_o = owner_stb & busy_o & ~to_hit;
    assign m_dat_o = s_dat_i;
    assign m_ack_o = grant & {NM{s_ack_i}};
    assign m_err_o = grant & {NM{to_hit & ~s_ack_i}};

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (NM=3, TIMEOUT=5).
module tb_wb_rr_arbiter;

    logic         clk;
    logic         rst;
    logic [95:0]  m_adr_i;
    logic [95:0]  m_dat_i;
    logic [11:0]  m_sel_i;
    logic [2:0]   m_we_i;
    logic [2:0]   cyc;
    logic [2:0]   stb;
    logic [31:0]  m_dat_o;
    logic [2:0]   m_ack_o;
    logic [2:0]   m_err_o;
    logic [31:0]  s_adr_o;
    logic [31:0]  s_dat_o;
    logic [3:0]   s_sel_o;
    logic         s_we_o;
    logic         s_cyc_o;
    logic         s_stb_o;
    logic [31:0]  s_dat_i;
    logic         s_ack_i;
    logic [2:0]   grant_o;
    logic         busy_o;

    int errors = 0;
    int checks = 0;

    wb_rr_arbiter #(
        .NM      (3),
        .AW      (32),
        .DW      (32),
        .TIMEOUT (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_we_i  (m_we_i),
        .m_cyc_i (cyc),
        .m_stb_i (stb),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acks0;
        int acks1;
        logic [2:0] exp;

        rst     = 1'b0;
        cyc     = '0;
        stb     = '0;
        s_ack_i = 1'b0;
        s_dat_i = 32'hDEAD_BEEF;
        m_adr_i = {32'hC000_0002, 32'hB000_0001, 32'hA000_0000};
        m_dat_i = {32'h2222_2222, 32'h1111_1111, 32'h0F0F_0F0F};
        m_sel_i = {4'hC, 4'h3, 4'hF};
        m_we_i  = 3'b101;

        // Reset state
        #1;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_busy",  32'(busy_o),  32'h0);
        chk("rst_cyc",   32'(s_cyc_o), 32'h0);
        chk("rst_stb",   32'(s_stb_o), 32'h0);
        chk("rst_ack",   32'(m_ack_o), 32'h0);
        chk("rst_err",   32'(m_err_o), 32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("idle_grant", 32'(grant_o), 32'h0);

        // Test 1: masters 0 and 2 together; 0 first, then 2 on the release edge
        cyc = 3'b101;
        stb = 3'b101;
        step();
        chk("t1_grant0", 32'(grant_o), 32'h1);
        chk("t1_scyc",   32'(s_cyc_o), 32'h1);
        chk("t1_sstb",   32'(s_stb_o), 32'h1);
        chk("t1_adr0",   s_adr_o, 32'hA000_0000);
        chk("t1_sel0",   32'(s_sel_o), 32'hF);
        chk("t1_we0",    32'(s_we_o), 32'h1);
        chk("t1_dat0",   s_dat_o, 32'h0F0F_0F0F);
        s_ack_i = 1'b1;
        #1;
        chk("t1_ack0",   32'(m_ack_o), 32'h1);
        chk("t1_rdat",   m_dat_o, 32'hDEAD_BEEF);
        step();
        cyc[0]  = 1'b0;
        stb[0]  = 1'b0;
        s_ack_i = 1'b0;
        #1;
        chk("t1_hold0",  32'(grant_o), 32'h1);
        chk("t1_cyc_off", 32'(s_cyc_o), 32'h0);
        step();
        chk("t1_grant2", 32'(grant_o), 32'h4);
        chk("t1_busy2",  32'(busy_o), 32'h1);
        chk("t1_adr2",   s_adr_o, 32'hC000_0002);
        chk("t1_sel2",   32'(s_sel_o), 32'hC);
        s_ack_i = 1'b1;
        #1;
        chk("t1_ack2",   32'(m_ack_o), 32'h4);
        step();
        cyc     = '0;
        stb     = '0;
        s_ack_i = 1'b0;
        step();
        chk("t1_idle",   32'(grant_o), 32'h0);

        // Test 2: all three busy, single-beat each -> 0,1,2,0,1,2 with no idle gap
        cyc = 3'b111;
        stb = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step();
            cyc = 3'b111;
            stb = 3'b111;
            exp = 3'(1 << (k % 3));
            chk("t2_grant", 32'(grant_o), 32'(exp));
            chk("t2_busy",  32'(busy_o), 32'h1);
            s_ack_i = 1'b1;
            #1;
            chk("t2_ack",   32'(m_ack_o), 32'(exp));
            step();
            s_ack_i = 1'b0;
            cyc     = cyc & ~exp;
            stb     = stb & ~exp;
            #1;
            chk("t2_nogap", 32'(busy_o), 32'h1);
            chk("t2_scyc",  32'(s_cyc_o), 32'h0);
        end
        cyc = '0;
        stb = '0;
        step();
        chk("t2_idle", 32'(grant_o), 32'h0);

        // Test 3: master 1 burst of 4 while master 0 waits
        cyc = 3'b010;
        stb = 3'b010;
        step();
        chk("t3_grant1", 32'(grant_o), 32'h2);
        cyc   = 3'b011;
        stb   = 3'b011;
        acks0 = 0;
        acks1 = 0;
        for (int b = 0; b < 4; b++) begin
            s_ack_i = 1'b1;
            #1;
            acks1 += int'(m_ack_o[1]);
            acks0 += int'(m_ack_o[0]);
            chk("t3_hold1", 32'(grant_o), 32'h2);
            step();
        end
        s_ack_i = 1'b0;
        cyc     = 3'b001;
        stb     = 3'b001;
        #1;
        chk("t3_acks1", 32'(acks1), 32'd4);
        chk("t3_acks0", 32'(acks0), 32'd0);
        chk("t3_still1", 32'(grant_o), 32'h2);
        step();
        chk("t3_grant0", 32'(grant_o), 32'h1);
        s_ack_i = 1'b1;
        #1;
        chk("t3_ack0", 32'(m_ack_o), 32'h1);
        step();
        cyc     = '0;
        stb     = '0;
        s_ack_i = 1'b0;
        step();
        chk("t3_idle", 32'(grant_o), 32'h0);

        // Test 4: no ack for master 2 -> err pulse 5 cycles after stb rises
        cyc = 3'b100;
        stb = 3'b100;
        step();
        chk("t4_grant2", 32'(grant_o), 32'h4);
        for (int c = 0; c <= 6; c++) begin
            chk("t4_err",  32'(m_err_o), (c == 5) ? 32'h4 : 32'h0);
            chk("t4_sstb", 32'(s_stb_o), (c == 5) ? 32'h0 : 32'h1);
            if (c < 6) step();
        end
        cyc = '0;
        stb = '0;
        step();
        chk("t4_idle", 32'(grant_o), 32'h0);

        // Test 5: ack lands on the timeout cycle -> ack wins, counter restarts from 0
        cyc = 3'b100;
        stb = 3'b100;
        step();
        chk("t5_grant2", 32'(grant_o), 32'h4);
        for (int c = 0; c < 5; c++) begin
            chk("t5_pre_err", 32'(m_err_o), 32'h0);
            step();
        end
        s_ack_i = 1'b1;
        #1;
        chk("t5_ack",    32'(m_ack_o), 32'h4);
        chk("t5_no_err", 32'(m_err_o), 32'h0);
        step();
        s_ack_i = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            chk("t5_restart_err", 32'(m_err_o), (c == 5) ? 32'h4 : 32'h0);
            if (c < 5) step();
        end
        cyc = '0;
        stb = '0;
        step();
        chk("t5_idle", 32'(grant_o), 32'h0);

        // Test 6: async reset while master 1 owns; master 0 wins afterwards
        cyc = 3'b010;
        stb = 3'b010;
        step();
        chk("t6_grant1", 32'(grant_o), 32'h2);
        chk("t6_scyc",   32'(s_cyc_o), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_grant", 32'(grant_o), 32'h0);
        chk("t6_rst_cyc",   32'(s_cyc_o), 32'h0);
        chk("t6_rst_stb",   32'(s_stb_o), 32'h0);
        chk("t6_rst_busy",  32'(busy_o),  32'h0);
        cyc = 3'b011;
        stb = 3'b011;
        #2;
        rst = 1'b1;
        step();
        chk("t6_grant0", 32'(grant_o), 32'h1);
        cyc = '0;
        stb = '0;
        step();
        chk("t6_idle", 32'(grant_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
